// File: rtl/i2s_tx.sv
// I2S transmitter: derives bclk/lrclk from clk, sends one mono sample on both slots and
// requests a new sample once per frame. Define I2S_LEFT_JUSTIFIED_EN for left-justified data.
module i2s_tx #(
  parameter int SAMPLE_W = 24,
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_req,
  output logic                underrun,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata
);

  localparam int FRAME_BITS = 2 * SLOT_W;
  localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_N   = BIT_W'(SLOT_W);
  localparam logic [BIT_W-1:0] SAMPLE_N = BIT_W'(SAMPLE_W);

  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                bclk_q, bclk_d;
  logic                lrclk_q, lrclk_d;
  logic                sdata_q, sdata_d;
  logic                req_q, req_d;
  logic                urun_q, urun_d;
  logic                got_q, got_d;
  logic [SAMPLE_W-1:0] hold_q, hold_d;
  logic [SAMPLE_W-1:0] frame_q, frame_d;

  logic                tick;
  logic                fall;
  logic                frame_start;
  logic [BIT_W-1:0]    bit_next;
  logic [BIT_W-1:0]    pos;
  logic [SAMPLE_W-1:0] shifted;
  logic                data_bit;

  always_comb begin
    tick        = (div_cnt_q == DIV_LAST);
    fall        = tick & bclk_q;
    frame_start = fall && (bit_cnt_q == BIT_LAST);

    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    bclk_d    = bclk_q ^ tick;

    bit_next = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
    pos      = (bit_next >= SLOT_N) ? bit_next - SLOT_N : bit_next;

    // frame_d is used for the data bit so the word loaded at frame start is already visible
    frame_d = frame_start ? hold_q : frame_q;
`ifdef I2S_LEFT_JUSTIFIED_EN
    shifted  = frame_d << pos;
    data_bit = (pos < SAMPLE_N) ? shifted[SAMPLE_W-1] : 1'b0;
`else
    shifted  = frame_d << (pos - BIT_W'(1));
    data_bit = ((pos != '0) && (pos <= SAMPLE_N)) ? shifted[SAMPLE_W-1] : 1'b0;
`endif

    bit_cnt_d = bit_cnt_q;
    lrclk_d   = lrclk_q;
    sdata_d   = sdata_q;
    if (fall) begin
      bit_cnt_d = bit_next;
      lrclk_d   = (bit_next >= SLOT_N);
      sdata_d   = data_bit;
    end

    // a strobe on the frame-start cycle wins over the clear and counts for the next frame
    hold_d = sample_valid ? sample_in : hold_q;
    got_d  = sample_valid | (got_q & ~frame_start);
    req_d  = frame_start;
    urun_d = frame_start & ~got_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
      bit_cnt_q <= BIT_LAST;
      bclk_q    <= 1'b0;
      lrclk_q   <= 1'b0;
      sdata_q   <= 1'b0;
      req_q     <= 1'b0;
      urun_q    <= 1'b0;
      got_q     <= 1'b0;
      hold_q    <= '0;
      frame_q   <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      bclk_q    <= bclk_d;
      lrclk_q   <= lrclk_d;
      sdata_q   <= sdata_d;
      req_q     <= req_d;
      urun_q    <= urun_d;
      got_q     <= got_d;
      hold_q    <= hold_d;
      frame_q   <= frame_d;
    end
  end

  assign sample_req = req_q;
  assign underrun   = urun_q;
  assign bclk       = bclk_q;
  assign lrclk      = lrclk_q;
  assign sdata      = sdata_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx: stimulus pushes the expected word/underrun for each frame,
// a monitor deserialises both slots and compares.
module tb_i2s_tx;
  localparam int SAMPLE_W  = 24;
  localparam int SLOT_W    = 32;
  localparam int BCLK_DIV  = 8;
  localparam int FRAME_CLK = 4 * SLOT_W * BCLK_DIV;

  logic                clk;
  logic                reset_n;
  logic [SAMPLE_W-1:0] sample_in;
  logic                sample_valid;
  logic                sample_req;
  logic                underrun;
  logic                bclk;
  logic                lrclk;
  logic                sdata;

  i2s_tx #(.SAMPLE_W(SAMPLE_W), .SLOT_W(SLOT_W), .BCLK_DIV(BCLK_DIV)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_req   (sample_req),
    .underrun     (underrun),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk  = 0;
  int n_pass = 0;
  int pushed = 0;
  int checked = 0;
  int last_req = -1;
  bit mon_en = 1'b1;
  logic [SAMPLE_W-1:0] m_hold;
  logic                m_got;
  logic [SAMPLE_W:0]   exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [SLOT_W-1:0] slot_pattern(input logic [SAMPLE_W-1:0] w);
`ifdef I2S_LEFT_JUSTIFIED_EN
    return {w, {(SLOT_W-SAMPLE_W){1'b0}}};
`else
    return {1'b0, w, {(SLOT_W-SAMPLE_W-1){1'b0}}};
`endif
  endfunction

  task automatic note_req();
    if (last_req >= 0) check("req_period", 64'(cyc - last_req), 64'(FRAME_CLK));
    last_req = cyc;
  endtask

  // model of one frame start: this frame sends the held word, underrun if nothing arrived
  task automatic push_frame();
    exp_q.push_back({~m_got, m_hold});
    pushed++;
    m_got = 1'b0;
    note_req();
  endtask

  task automatic wait_req();
    int n = 0;
    while (!sample_req && n < 3 * FRAME_CLK) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", 64'(sample_req), 64'd1);
  endtask

  task automatic strobe(input logic [SAMPLE_W-1:0] v);
    sample_in    = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    m_hold = v;
    m_got  = 1'b1;
  endtask

  // mode 0: idle, 1: one strobe, 2: strobe on the next frame-start edge, 3: two strobes
  task automatic do_frame(input int mode, input logic [SAMPLE_W-1:0] v);
    wait_req();
    push_frame();
    case (mode)
      1: strobe(v);
      3: begin
        strobe(~v);
        strobe(v);
      end
      2: begin
        @(negedge clk);
        repeat (FRAME_CLK - 2) @(negedge clk);
        sample_in    = v;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        check("strobe_on_frame_start", 64'(sample_req), 64'd1);
        wait_req();
        push_frame();
        m_hold = v;
        m_got  = 1'b1;
        @(negedge clk);
      end
      default: @(negedge clk);
    endcase
  endtask

  task automatic release_and_first_req();
    int n = 0;
    reset_n = 1'b1;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!sample_req && n < 200);
    // release lands mid-cycle, so the first edge that sees it is counted too
    check("first_req_edges", 64'(n), 64'(2 * BCLK_DIV));
    push_frame();
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (checked != pushed && n < 4 * FRAME_CLK) begin
      @(negedge clk);
      n++;
    end
    check("frames_checked", 64'(checked), 64'(pushed));
  endtask

  task automatic wait_edge(input bit use_lr, input bit rise, output int t);
    logic prev, cur;
    t = -1;
    prev = use_lr ? lrclk : bclk;
    for (int n = 0; n < 3 * FRAME_CLK; n++) begin
      @(negedge clk);
      cur = use_lr ? lrclk : bclk;
      if (cur == rise && prev != rise) begin
        t = cyc;
        break;
      end
      prev = cur;
    end
  endtask

  task automatic timing_checks();
    int t0, t1, t2, t3, t4;
    wait_edge(1'b0, 1'b1, t0);
    wait_edge(1'b0, 1'b1, t1);
    check("bclk_period", 64'(t1 - t0), 64'(2 * BCLK_DIV));
    wait_edge(1'b1, 1'b1, t2);
    wait_edge(1'b1, 1'b0, t3);
    wait_edge(1'b1, 1'b1, t4);
    check("lrclk_high", 64'(t3 - t2), 64'(FRAME_CLK / 2));
    check("lrclk_period", 64'(t4 - t2), 64'(FRAME_CLK));
  endtask

  // monitor: one frame = 64 bclk rising edges after sample_req
  initial begin
    logic [SLOT_W-1:0]     left, right;
    logic [2*SLOT_W-1:0]   lr;
    logic [SAMPLE_W:0]     e;
    logic                  ur, pb, hit;
    int                    n;
    forever begin
      @(negedge clk);
      if (!(mon_en && sample_req)) continue;
      ur = underrun;
      pb = bclk;
      left = '0;
      right = '0;
      lr = '0;
      for (int k = 0; k < 2 * SLOT_W; k++) begin
        hit = 1'b0;
        n = 0;
        while (!hit && n < 8 * BCLK_DIV) begin
          @(negedge clk);
          hit = bclk && !pb;
          pb = bclk;
          n++;
        end
        if (k < SLOT_W) left = {left[SLOT_W-2:0], sdata};
        else right = {right[SLOT_W-2:0], sdata};
        lr = {lr[2*SLOT_W-2:0], lrclk};
      end
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL frame_unexpected: got frame with left %0h, no expected entry", left);
      end else begin
        e = exp_q.pop_front();
        check("left_slot", 64'(left), 64'(slot_pattern(e[SAMPLE_W-1:0])));
        check("right_slot", 64'(right), 64'(slot_pattern(e[SAMPLE_W-1:0])));
        check("lrclk_slots", lr, {{SLOT_W{1'b0}}, {SLOT_W{1'b1}}});
        check("underrun", 64'(ur), 64'(e[SAMPLE_W]));
      end
      checked++;
    end
  end

  initial begin
    int n;
    logic pb;
    sample_in    = '0;
    sample_valid = 1'b0;
    reset_n      = 1'b0;
    m_hold       = '0;
    m_got        = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({bclk, lrclk, sdata, sample_req, underrun}), 64'd0);

    release_and_first_req();
    fork
      timing_checks();
    join_none
    do_frame(0, '0);
    do_frame(1, 24'hA5C3F0);
    do_frame(1, 24'hA5C3F0);
    do_frame(2, 24'h800001);
    do_frame(1, 24'h123456);
    do_frame(0, '0);
    do_frame(0, '0);
    do_frame(3, 24'h7FFFFE);
    do_frame(0, '0);
    do_frame(0, '0);
    drain();
    mon_en = 1'b0;

    // reset in the middle of the right slot, at bit_cnt 40
    wait_req();
    pb = bclk;
    n = 0;
    for (int f = 0; f < 40 && n < 2 * FRAME_CLK; ) begin
      @(negedge clk);
      n++;
      if (!bclk && pb) f++;
      pb = bclk;
    end
    repeat (BCLK_DIV + 1) @(negedge clk);
    check("pre_reset_lines", 64'({bclk, lrclk, sdata}), 64'b111);
    #2 reset_n = 1'b0;
    #1 check("async_reset_lines", 64'({bclk, lrclk, sdata, sample_req, underrun}), 64'd0);
    repeat (2) @(negedge clk);
    m_hold   = '0;
    m_got    = 1'b0;
    last_req = -1;
    mon_en   = 1'b1;
    release_and_first_req();
    do_frame(0, '0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
